// File: rtl/scroll_msg_display.sv
// Scrolling "HELLO" message across NUM_DIGITS active-low 7-segment digits.
// Optional pass counter output enabled by defining SCROLL_PASS_COUNT_EN.
module scroll_msg_display #(
    parameter int NUM_DIGITS = 8,
    parameter int CODE_W     = 3,
    parameter int DIV_W      = 4
) (
    input  logic                         KEY,
    input  logic                         SW,
    input  logic                         run,
    input  logic                         dir,
    input  logic                         clear,
    input  logic [DIV_W-1:0]             rate,
    output logic [NUM_DIGITS*CODE_W-1:0] codes,
    output logic [NUM_DIGITS*7-1:0]      hex,
    output logic                         step,
`ifdef SCROLL_PASS_COUNT_EN
    output logic [7:0]                   passes,
`endif
    output logic [1:0]                   state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [CODE_W-1:0] CODE_H     = CODE_W'(0);
    localparam logic [CODE_W-1:0] CODE_E     = CODE_W'(1);
    localparam logic [CODE_W-1:0] CODE_L     = CODE_W'(2);
    localparam logic [CODE_W-1:0] CODE_O     = CODE_W'(3);
    localparam logic [CODE_W-1:0] CODE_BLANK = CODE_W'(7);

    state_t            state_q;
    state_t            state_d;
    logic [CODE_W-1:0] digit [NUM_DIGITS];
    logic [2:0]        idx;
    logic [DIV_W-1:0]  cnt;
    logic              rate_hit;
    logic              do_step;
    logic [CODE_W-1:0] rom_code;

    function automatic logic [CODE_W-1:0] rom_char(input logic [2:0] i);
        logic [CODE_W-1:0] c;
        c = CODE_BLANK;
        case (i)
            3'd0:       c = CODE_H;
            3'd1:       c = CODE_E;
            3'd2, 3'd3: c = CODE_L;
            3'd4:       c = CODE_O;
            default:    c = CODE_BLANK;
        endcase
        return c;
    endfunction

    function automatic logic [6:0] seg_decode(input logic [CODE_W-1:0] c);
        logic [6:0] s;
        s = 7'h7F;
        if (c == CODE_H)      s = 7'h09;
        else if (c == CODE_E) s = 7'h06;
        else if (c == CODE_L) s = 7'h47;
        else if (c == CODE_O) s = 7'h40;
        return s;
    endfunction

    assign state    = state_q;
    assign rom_code = rom_char(idx);
    assign rate_hit = (cnt >= rate);
    // Clear wins over a pending step, so the shift is suppressed outright.
    assign do_step  = (state_q == RUN) && rate_hit && !clear;

    always_ff @(posedge KEY or posedge SW) begin
        if (SW) state_q <= IDLE;
        else    state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (run)  state_d = RUN;
                RUN:     if (!run) state_d = HOLD;
                HOLD:    if (run)  state_d = RUN;
                default: state_d = IDLE;
            endcase
        end
    end

    // Prescaler: counts in RUN, frozen in HOLD, held at zero otherwise.
    always_ff @(posedge KEY or posedge SW) begin
        if (SW) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else begin
            case (state_q)
                RUN:     cnt <= rate_hit ? '0 : cnt + DIV_W'(1);
                HOLD:    cnt <= cnt;
                default: cnt <= '0;
            endcase
        end
    end

    always_ff @(posedge KEY or posedge SW) begin
        if (SW) begin
            step <= 1'b0;
            idx  <= 3'd0;
            for (int i = 0; i < NUM_DIGITS; i++) digit[i] <= CODE_BLANK;
        end else if (clear) begin
            step <= 1'b0;
            idx  <= 3'd0;
            for (int i = 0; i < NUM_DIGITS; i++) digit[i] <= CODE_BLANK;
        end else begin
            step <= do_step;
            if (do_step) begin
                if (!dir) begin
                    digit[0] <= rom_code;
                    for (int i = 1; i < NUM_DIGITS; i++) digit[i] <= digit[i-1];
                    idx <= idx + 3'd1;
                end else begin
                    digit[NUM_DIGITS-1] <= rom_code;
                    for (int i = 0; i < NUM_DIGITS-1; i++) digit[i] <= digit[i+1];
                    idx <= idx - 3'd1;
                end
            end
        end
    end

`ifdef SCROLL_PASS_COUNT_EN
    logic idx_wrap;
    assign idx_wrap = dir ? (idx == 3'd0) : (idx == 3'd7);

    always_ff @(posedge KEY or posedge SW) begin
        if (SW) begin
            passes <= 8'd0;
        end else if (clear) begin
            passes <= 8'd0;
        end else if (do_step && idx_wrap && (passes != 8'hFF)) begin
            passes <= passes + 8'd1;
        end
    end
`endif

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        assign codes[g*CODE_W +: CODE_W] = digit[g];
        assign hex[g*7 +: 7]             = seg_decode(digit[g]);
    end

endmodule

// File: tb/tb_scroll_msg_display.sv
// Directed bench for scroll_msg_display (default 8 digits, 3-bit codes).
// Pass-counter checks are built when SCROLL_PASS_COUNT_EN is defined.
module tb_scroll_msg_display;

    logic        KEY = 1'b0;
    logic        SW  = 1'b0;
    logic        run = 1'b0;
    logic        dir = 1'b0;
    logic        clear = 1'b0;
    logic [3:0]  rate = 4'd0;
    logic [23:0] codes;
    logic [55:0] hex;
    logic        step;
    logic [1:0]  state;
`ifdef SCROLL_PASS_COUNT_EN
    logic [7:0]  passes;
`endif

    int passed = 0;
    int total  = 0;
    int e[8];

    scroll_msg_display dut (
        .KEY   (KEY),
        .SW    (SW),
        .run   (run),
        .dir   (dir),
        .clear (clear),
        .rate  (rate),
        .codes (codes),
        .hex   (hex),
        .step  (step),
`ifdef SCROLL_PASS_COUNT_EN
        .passes(passes),
`endif
        .state (state)
    );

    initial forever #5 KEY = ~KEY;

    task automatic tick();
        @(posedge KEY);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [6:0] seg(input int c);
        case (c)
            0:       return 7'h09;
            1:       return 7'h06;
            2:       return 7'h47;
            3:       return 7'h40;
            default: return 7'h7F;
        endcase
    endfunction

    // e[i] holds the expected code of digit i
    task automatic check_digits(input string tag);
        logic [23:0] ec;
        logic [55:0] eh;
        for (int i = 0; i < 8; i++) begin
            ec[i*3 +: 3] = 3'(e[i]);
            eh[i*7 +: 7] = seg(e[i]);
        end
        check({tag, "_codes"}, 64'(codes), 64'(ec));
        check({tag, "_hex"}, 64'(hex), 64'(eh));
    endtask

    initial begin
        int pat[8];
        int n;

        // Reset
        #1 SW = 1'b1;
        #10;
        e = '{7, 7, 7, 7, 7, 7, 7, 7};
        check("rst_state", 64'(state), 64'd0);
        check("rst_step", 64'(step), 64'd0);
        check_digits("rst");
        #3 SW = 1'b0;

        // Left scroll at full rate
        tick();
        run = 1'b1; dir = 1'b0; rate = 4'd0;
        tick();
        check("left_enter_state", 64'(state), 64'd1);
        check("left_enter_step", 64'(step), 64'd0);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("left_step", 64'(step), 64'd1);
        end
        e = '{3, 2, 2, 1, 0, 7, 7, 7};
        check_digits("left5");
        check("left_hex4", 64'(hex[4*7 +: 7]), 64'h09);
        check("left_hex0", 64'(hex[0 +: 7]), 64'h40);

        // Clear on the same edge as a due step
        run = 1'b0; clear = 1'b1;
        tick();
        check("clr_state", 64'(state), 64'd0);
        check("clr_step", 64'(step), 64'd0);
        e = '{7, 7, 7, 7, 7, 7, 7, 7};
        check_digits("clr");
        clear = 1'b0; run = 1'b1;
        tick();
        tick();
        e = '{0, 7, 7, 7, 7, 7, 7, 7};
        check_digits("clr_idx0");
        run = 1'b0; clear = 1'b1;
        tick();
        clear = 1'b0;

        // Right scroll and index wrap
        dir = 1'b1; run = 1'b1;
        tick();
        check("right_enter_state", 64'(state), 64'd1);
        tick();
        check("right_step1", 64'(step), 64'd1);
        e = '{7, 7, 7, 7, 7, 7, 7, 0};
        check_digits("right1");
        tick();
        e = '{7, 7, 7, 7, 7, 7, 0, 7};
        check_digits("right2");
        run = 1'b0; clear = 1'b1;
        tick();
        clear = 1'b0;

        // Prescaler at rate 3, then hold and resume
        dir = 1'b0; rate = 4'd3; run = 1'b1;
        tick();
        check("pre_enter_state", 64'(state), 64'd1);
        pat = '{0, 0, 0, 1, 0, 0, 0, 1};
        for (int k = 0; k < 8; k++) begin
            tick();
            check("pre_step", 64'(step), 64'(pat[k]));
        end
        e = '{1, 0, 7, 7, 7, 7, 7, 7};
        check_digits("pre2");
        tick();
        run = 1'b0;
        tick();
        check("hold_state", 64'(state), 64'd2);
        for (int k = 0; k < 10; k++) begin
            tick();
            check("hold_step", 64'(step), 64'd0);
        end
        check_digits("hold");
        run = 1'b1;
        tick();
        check("resume_state", 64'(state), 64'd1);
        check("resume_step0", 64'(step), 64'd0);
        tick();
        check("resume_step1", 64'(step), 64'd0);
        tick();
        check("resume_step2", 64'(step), 64'd1);
        e = '{2, 1, 0, 7, 7, 7, 7, 7};
        check_digits("resume");

        // Asynchronous reset mid-operation
        rate = 4'd0;
        n = $urandom_range(1, 7);
        for (int k = 0; k < n; k++) tick();
        #1 SW = 1'b1;
        #1;
        e = '{7, 7, 7, 7, 7, 7, 7, 7};
        check("arst_state", 64'(state), 64'd0);
        check("arst_step", 64'(step), 64'd0);
        check_digits("arst");
        #2 SW = 1'b0;
        run = 1'b0;

`ifdef SCROLL_PASS_COUNT_EN
        tick();
        check("pass_rst", 64'(passes), 64'd0);
        run = 1'b1; dir = 1'b0; rate = 4'd0;
        tick();
        for (int k = 0; k < 16; k++) tick();
        check("pass_16", 64'(passes), 64'd2);
        for (int k = 0; k < 2100; k++) tick();
        check("pass_sat", 64'(passes), 64'd255);
        run = 1'b0; clear = 1'b1;
        tick();
        check("pass_clr", 64'(passes), 64'd0);
        clear = 1'b0;
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
